// File: rtl/conv_host_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared widths, bank-select encodings and FSM states for the
//            convolution accelerator host-side memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned DATA_W    = 20;
    localparam int unsigned NUM_BANKS = 5;

    localparam logic [2:0] CSEL_IMG  = 3'd0;
    localparam logic [2:0] CSEL_L0K0 = 3'd1;
    localparam logic [2:0] CSEL_L0K1 = 3'd2;
    localparam logic [2:0] CSEL_L1K0 = 3'd3;
    localparam logic [2:0] CSEL_L1K1 = 3'd4;
    localparam logic [2:0] CSEL_L2   = 3'd5;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr, input int unsigned depth);
        return 32'(addr) < depth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_host_mem_bank_ram.sv
`default_nettype none
// ============================================================================
// Module   : conv_bank_ram
// Brief    : Simple dual-port RAM, one write port, registered read-first port.
// Revision : 1.0 - initial release
// ============================================================================
module conv_bank_ram
    import conv_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = 12,
    parameter int unsigned DW    = DATA_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Non-blocking write and read in one process gives old data on collision
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        r_rdata <= r_mem[raddr];
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/conv_host_mem.sv
`default_nettype none
// ============================================================================
// Module   : conv_host_mem
// Brief    : Host-side memory responder: image ROM, five layer banks, run
//            handshake tracking with watchdog and illegal-access flagging.
// Revision : 1.0 - initial release
// ============================================================================
module conv_host_mem
    import conv_pkg::*;
#(
    parameter int unsigned IMG_DEPTH = 4096,
    parameter int unsigned L0_DEPTH  = 4096,
    parameter int unsigned L1_DEPTH  = 1024,
    parameter int unsigned L2_DEPTH  = 2048,
    parameter int unsigned WATCHDOG  = 32'd16777216
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              img_we,
    input  logic [ADDR_W-1:0] img_waddr,
    input  logic [DATA_W-1:0] img_wdata,
    output logic              ready,
    input  logic              busy,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] idata,
    input  logic              cwr,
    input  logic [ADDR_W-1:0] caddr_wr,
    input  logic [DATA_W-1:0] cdata_wr,
    input  logic              crd,
    input  logic [ADDR_W-1:0] caddr_rd,
    output logic [DATA_W-1:0] cdata_rd,
    input  logic [2:0]        csel,
    output logic              done,
    output logic              timeout,
    output logic              err,
    output logic [31:0]       run_cycles,
    input  logic [2:0]        dbg_sel,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned IMG_AW = $clog2(IMG_DEPTH);

    // Invalid selects report depth 0, so the range check also rejects them
    function automatic int unsigned sel_depth(input logic [2:0] sel);
        case (sel)
            CSEL_L0K0, CSEL_L0K1: return L0_DEPTH;
            CSEL_L1K0, CSEL_L1K1: return L1_DEPTH;
            CSEL_L2:              return L2_DEPTH;
            default:              return 0;
        endcase
    endfunction

    state_t              r_state;
    state_t              w_next;
    logic                w_run;
    logic                w_host;
    logic                w_timeout;
    logic                w_wr_ok;
    logic                w_rd_ok;
    logic                w_dbg_ok;
    logic                w_img_we;
    logic                w_err_evt;
    logic [ADDR_W-1:0]   w_bank_raddr;
    logic [DATA_W-1:0]   w_bank_q [NUM_BANKS];
    logic [DATA_W-1:0]   w_img_q;
    logic [DATA_W-1:0]   w_img_dbg_q;
    logic [DATA_W-1:0]   w_rd_val;
    logic [2:0]          w_dbg_idx;

    logic                r_idata_ok;
    logic                r_crd_q;
    logic                r_rd_ok;
    logic [2:0]          r_rd_idx;
    logic [DATA_W-1:0]   r_cdata_hold;
    logic                r_dbg_ok;
    logic [2:0]          r_dbg_sel;
    logic                r_done;
    logic                r_timeout;
    logic                r_err;
    logic [31:0]         r_run_cycles;

    assign w_run        = (r_state == ST_RUN);
    assign w_host       = (r_state == ST_LOAD) || (r_state == ST_DONE);
    assign w_timeout    = (r_run_cycles == WATCHDOG);
    assign w_wr_ok      = cwr && w_run && in_range(caddr_wr, sel_depth(csel));
    assign w_rd_ok      = crd && w_run && in_range(caddr_rd, sel_depth(csel));
    assign w_dbg_ok     = w_host && in_range(dbg_addr,
                              (dbg_sel == CSEL_IMG) ? IMG_DEPTH : sel_depth(dbg_sel));
    assign w_img_we     = img_we && w_host && in_range(img_waddr, IMG_DEPTH);
    assign w_err_evt    = (cwr && !w_wr_ok) || (crd && !w_rd_ok) || (img_we && !w_host);
    assign w_bank_raddr = w_run ? caddr_rd : dbg_addr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LOAD:  if (start) w_next = ST_READY;
            ST_READY: if (busy)  w_next = ST_RUN;
            ST_RUN:   if (w_timeout || !busy) w_next = ST_DONE;
            ST_DONE:  if (start) w_next = ST_READY;
            default:  w_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_err        <= 1'b0;
            r_run_cycles <= '0;
        end else begin
            case (r_state)
                ST_READY: if (busy) r_run_cycles <= '0;
                ST_RUN: begin
                    if (w_timeout) begin
                        r_timeout <= 1'b1;
                    end else begin
                        if (r_run_cycles != '1) r_run_cycles <= r_run_cycles + 32'd1;
                        if (!busy) r_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        r_done       <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_run_cycles <= '0;
                    end
                end
                default: ;
            endcase
            r_err <= (r_err && !((r_state == ST_DONE) && start)) || w_err_evt;
        end
    end

    // Read-side bookkeeping: the RAM outputs are never reset, so validity flags gate them
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idata_ok   <= 1'b0;
            r_crd_q      <= 1'b0;
            r_rd_ok      <= 1'b0;
            r_rd_idx     <= '0;
            r_cdata_hold <= '0;
            r_dbg_ok     <= 1'b0;
            r_dbg_sel    <= '0;
        end else begin
            r_idata_ok   <= in_range(iaddr, IMG_DEPTH);
            r_crd_q      <= crd;
            r_rd_ok      <= w_rd_ok;
            r_rd_idx     <= csel - 3'd1;
            r_cdata_hold <= cdata_rd;
            r_dbg_ok     <= w_dbg_ok;
            r_dbg_sel    <= dbg_sel;
        end
    end

    // Accelerator image port
    conv_bank_ram #(.DEPTH(IMG_DEPTH), .AW(IMG_AW), .DW(DATA_W)) u_img_rom (
        .clk   (clk),
        .we    (w_img_we),
        .waddr (img_waddr[IMG_AW-1:0]),
        .wdata (img_wdata),
        .raddr (iaddr[IMG_AW-1:0]),
        .rdata (w_img_q)
    );

    // Shadow copy so host readback never disturbs the accelerator's idata stream
    conv_bank_ram #(.DEPTH(IMG_DEPTH), .AW(IMG_AW), .DW(DATA_W)) u_img_dbg (
        .clk   (clk),
        .we    (w_img_we),
        .waddr (img_waddr[IMG_AW-1:0]),
        .wdata (img_wdata),
        .raddr (dbg_addr[IMG_AW-1:0]),
        .rdata (w_img_dbg_q)
    );

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        localparam int unsigned DEP = (k < 2) ? L0_DEPTH : (k < 4) ? L1_DEPTH : L2_DEPTH;
        localparam int unsigned AW  = $clog2(DEP);
        conv_bank_ram #(.DEPTH(DEP), .AW(AW), .DW(DATA_W)) u_bank (
            .clk   (clk),
            .we    (w_wr_ok && (csel == 3'(k + 1))),
            .waddr (caddr_wr[AW-1:0]),
            .wdata (cdata_wr),
            .raddr (w_bank_raddr[AW-1:0]),
            .rdata (w_bank_q[k])
        );
    end

    assign w_dbg_idx  = r_dbg_sel - 3'd1;
    assign w_rd_val   = r_rd_ok ? w_bank_q[r_rd_idx] : '0;
    assign cdata_rd   = r_crd_q ? w_rd_val : r_cdata_hold;
    assign idata      = r_idata_ok ? w_img_q : '0;
    assign dbg_data   = (w_host && r_dbg_ok)
                        ? ((r_dbg_sel == CSEL_IMG) ? w_img_dbg_q : w_bank_q[w_dbg_idx])
                        : '0;
    assign ready      = (r_state == ST_READY);
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign err        = r_err;
    assign run_cycles = r_run_cycles;

endmodule
`default_nettype wire

// File: tb/tb_conv_host_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_host_mem
// Brief    : Directed self-checking bench for conv_host_mem (default watchdog
//            instance plus a short-watchdog instance sharing the stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_host_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        img_we;
    logic [11:0] img_waddr;
    logic [19:0] img_wdata;
    logic        busy;
    logic [11:0] iaddr;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [2:0]  csel;
    logic [2:0]  dbg_sel;
    logic [11:0] dbg_addr;

    logic        ready, done, timeout, err;
    logic [19:0] idata, cdata_rd, dbg_data;
    logic [31:0] run_cycles;

    logic        ready2, done2, timeout2, err2;
    logic [19:0] idata2, cdata_rd2, dbg_data2;
    logic [31:0] run_cycles2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cyc0     = 0;
    int n_ready  = 0;

    always #5 clk = ~clk;

    conv_host_mem u_dut (
        .clk(clk), .reset(reset), .start(start), .img_we(img_we),
        .img_waddr(img_waddr), .img_wdata(img_wdata), .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .csel(csel), .done(done), .timeout(timeout), .err(err),
        .run_cycles(run_cycles), .dbg_sel(dbg_sel), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    conv_host_mem #(.WATCHDOG(50)) u_dut_wd (
        .clk(clk), .reset(reset), .start(start), .img_we(img_we),
        .img_waddr(img_waddr), .img_wdata(img_wdata), .ready(ready2), .busy(busy),
        .iaddr(iaddr), .idata(idata2), .cwr(cwr), .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd2),
        .csel(csel), .done(done2), .timeout(timeout2), .err(err2),
        .run_cycles(run_cycles2), .dbg_sel(dbg_sel), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [11:0] a, input logic [19:0] d);
        cwr = 1'b1; csel = sel; caddr_wr = a; cdata_wr = d; crd = 1'b0;
        tick();
        cwr = 1'b0;
    endtask

    task automatic rd(input logic [2:0] sel, input logic [11:0] a);
        crd = 1'b1; csel = sel; caddr_rd = a; cwr = 1'b0;
        tick();
        crd = 1'b0;
    endtask

    task automatic dbg(input logic [2:0] sel, input logic [11:0] a);
        dbg_sel = sel; dbg_addr = a;
        tick();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; img_we = 1'b0; img_waddr = '0; img_wdata = '0;
        busy = 1'b0; iaddr = '0; cwr = 1'b0; caddr_wr = '0; cdata_wr = '0;
        crd = 1'b0; caddr_rd = '0; csel = 3'd0; dbg_sel = 3'd0; dbg_addr = '0;
        tick(); tick();
        check("rst_ready", ready, 0);
        check("rst_idata", idata, 0);
        check("rst_cdata_rd", cdata_rd, 0);
        check("rst_flags", {done, timeout, err}, 0);
        check("rst_run_cycles", run_cycles, 0);
        check("rst_dbg_data", dbg_data, 0);
        reset = 1'b1;

        for (int n = 0; n < 4096; n++) begin
            img_we = 1'b1; img_waddr = 12'(n); img_wdata = 20'(n);
            tick();
        end
        img_we = 1'b0;

        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ready) n_ready++;
            tick();
        end
        busy = 1'b1;
        if (ready) n_ready++;
        tick();
        cyc0 = cyc;
        check("ready_cycles", n_ready, 11);
        check("ready_fall", ready, 0);

        wr(3'd3, 12'h3FF, 20'hABCDE);
        rd(3'd3, 12'h3FF);
        check("l1_wr_rd", cdata_rd, 20'hABCDE);
        check("l1_no_err", err, 0);
        wr(3'd3, 12'h000, 20'h33333);
        wr(3'd5, 12'h005, 20'h55555);
        wr(3'd1, 12'h005, 20'h11111);

        cwr = 1'b1; crd = 1'b1; csel = 3'd1; caddr_wr = 12'h005; caddr_rd = 12'h005;
        cdata_wr = 20'h22222;
        tick();
        cwr = 1'b0; crd = 1'b0;
        check("collide_old", cdata_rd, 20'h11111);
        rd(3'd1, 12'h005);
        check("collide_new", cdata_rd, 20'h22222);
        tick();
        check("cdata_hold", cdata_rd, 20'h22222);

        iaddr = 12'h123; tick();
        check("idata", idata, 20'h00123);

        wr(3'd6, 12'h005, 20'h66666);
        check("err_csel6", err, 1);
        wr(3'd3, 12'h400, 20'h44444);
        rd(3'd6, 12'h005);
        check("bad_rd_zero", cdata_rd, 0);
        rd(3'd5, 12'h005);
        check("l2_rd", cdata_rd, 20'h55555);

        while (cyc - cyc0 < 99) tick();
        busy = 1'b0;
        tick();
        check("done", done, 1);
        check("timeout_clear", timeout, 0);
        check("run_cycles", run_cycles, 100);
        check("wd_timeout", timeout2, 1);
        check("wd_done", done2, 0);
        tick();
        check("run_cycles_hold", run_cycles, 100);
        check("err_sticky", err, 1);

        dbg(3'd3, 12'h3FF); check("dbg_l1_3ff", dbg_data, 20'hABCDE);
        dbg(3'd3, 12'h000); check("dbg_l1_000", dbg_data, 20'h33333);
        dbg(3'd1, 12'h005); check("dbg_l0_005", dbg_data, 20'h22222);
        dbg(3'd5, 12'h005); check("dbg_l2_005", dbg_data, 20'h55555);
        dbg(3'd0, 12'h07A); check("dbg_img", dbg_data, 20'h0007A);
        check("cdata_hold_done", cdata_rd, 20'h55555);

        start = 1'b1; tick(); start = 1'b0;
        check("restart_ready", ready, 1);
        check("restart_flags", {done, timeout, err}, 0);
        check("restart_cycles", run_cycles, 0);
        check("dbg_ready_zero", dbg_data, 0);
        img_we = 1'b1; img_waddr = 12'h200; img_wdata = 20'hFFFFF;
        tick();
        img_we = 1'b0;
        check("err_img_we_ready", err, 1);

        busy = 1'b1; tick();
        wr(3'd2, 12'h007, 20'h2A2A2);
        check("run_cycles_run2", run_cycles, 1);
        reset = 1'b0; tick();
        check("mid_rst_ready", ready, 0);
        check("mid_rst_flags", {done, timeout, err}, 0);
        check("mid_rst_cycles", run_cycles, 0);
        check("mid_rst_data", {cdata_rd, dbg_data, idata}, 0);
        reset = 1'b1; busy = 1'b0;
        dbg(3'd2, 12'h007); check("dbg_after_rst", dbg_data, 20'h2A2A2);
        dbg(3'd0, 12'h200); check("img_we_dropped", dbg_data, 20'h00200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
